// File: rtl/gpio_bcd_display_if.sv
// Bundle between a core GPIO output register and its BCD / seven-segment display block.
interface gpio_bcd_display_if #(
  parameter int unsigned NDIGITS = 8
) ();
  logic [31:0]          value_in;
  logic [4*NDIGITS-1:0] bcd_out;
  logic [7*NDIGITS-1:0] seg_out;
  logic                 overflow;
  logic                 busy;
  logic                 valid;

  modport master (
    output value_in,
    input  bcd_out,
    input  seg_out,
    input  overflow,
    input  busy,
    input  valid
  );

  modport slave (
    input  value_in,
    output bcd_out,
    output seg_out,
    output overflow,
    output busy,
    output valid
  );
endinterface

// File: rtl/gpio_bcd_display.sv
// Iterative double-dabble converter driving NDIGITS active-low seven-segment digits.
// Optional macro GPIO_BCD_LEADING_ZERO_BLANK_EN blanks zero digits above the leading digit.
module gpio_bcd_display #(
  parameter int unsigned NDIGITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  gpio_bcd_display_if.slave  bus
);

  localparam int unsigned AccDigits = 10;

  typedef enum logic [1:0] {StIdle, StConvert, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   first_q, first_d;
  logic [31:0]            last_value_q, last_value_d;
  logic [31:0]            shift_q, shift_d;
  logic [4*AccDigits-1:0] acc_q, acc_d, acc_adj;
  logic [4:0]             cnt_q, cnt_d;
  logic [4*NDIGITS-1:0]   bcd_q, bcd_d;
  logic [7*NDIGITS-1:0]   seg_q, seg_d, seg_next;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   acc_ovf;
  logic [NDIGITS-1:0]     digit_blank;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Add-3 correction per digit; 4-bit wrap, no carry into the neighbour.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(AccDigits); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    acc_ovf = 1'b0;
    for (int i = 0; i < int'(AccDigits); i++) begin
      if (i >= int'(NDIGITS)) begin
        acc_ovf = acc_ovf | (|acc_q[4*i +: 4]);
      end
    end
  end

`ifdef GPIO_BCD_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen;
    seen        = 1'b0;
    digit_blank = '0;
    for (int i = int'(NDIGITS) - 1; i >= 1; i--) begin
      seen           = seen | (|acc_q[4*i +: 4]);
      digit_blank[i] = ~seen;
    end
  end
`else
  assign digit_blank = '0;
`endif

  // Dashes on overflow win over blanking.
  always_comb begin
    seg_next = '1;
    for (int i = 0; i < int'(NDIGITS); i++) begin
      if (acc_ovf) begin
        seg_next[7*i +: 7] = 7'h3F;
      end else if (digit_blank[i]) begin
        seg_next[7*i +: 7] = 7'h7F;
      end else begin
        seg_next[7*i +: 7] = seg_encode(acc_q[4*i +: 4]);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    last_value_d = last_value_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    bcd_d        = bcd_q;
    seg_d        = seg_q;
    overflow_d   = overflow_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (first_q || (bus.value_in != last_value_q)) begin
          shift_d      = bus.value_in;
          last_value_d = bus.value_in;
          acc_d        = '0;
          cnt_d        = '0;
          first_d      = 1'b0;
          busy_d       = 1'b1;
          state_d      = StConvert;
        end
      end
      StConvert: begin
        acc_d   = {acc_adj[4*AccDigits-2:0], shift_q[31]};
        shift_d = {shift_q[30:0], 1'b0};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d      = acc_q[4*NDIGITS-1:0];
        overflow_d = acc_ovf;
        seg_d      = seg_next;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      first_q      <= 1'b1;
      last_value_q <= '0;
      shift_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      bcd_q        <= '0;
      seg_q        <= '1;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      last_value_q <= last_value_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      bcd_q        <= bcd_d;
      seg_q        <= seg_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.bcd_out  = bcd_q;
  assign bus.seg_out  = seg_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;

endmodule

// File: tb/tb_gpio_bcd_display.sv
// Randomized bench for gpio_bcd_display against a decimal-arithmetic reference model.
module tb_gpio_bcd_display;
  localparam int unsigned NDIGITS = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  gpio_bcd_display_if #(.NDIGITS(NDIGITS)) bus ();

  gpio_bcd_display #(.NDIGITS(NDIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic [4*NDIGITS-1:0] exp_bcd;
  logic [7*NDIGITS-1:0] exp_seg;
  logic                 exp_ovf, exp_busy, exp_valid;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a conversion takes 33 edges after the start edge; result from / and %.
  initial begin
    bit              m_first;
    int              m_left;
    longint unsigned m_last, v;
    int              dig [NDIGITS];
    int              top;
    m_first = 1'b1;
    m_left  = 0;
    m_last  = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_first   = 1'b1;
        m_left    = 0;
        exp_bcd   = '0;
        exp_seg   = '1;
        exp_ovf   = 1'b0;
        exp_busy  = 1'b0;
        exp_valid = 1'b0;
      end else begin
        exp_valid = 1'b0;
        if (m_left == 0) begin
          if (m_first || (longint'(bus.value_in) != m_last)) begin
            m_last   = longint'(bus.value_in);
            m_first  = 1'b0;
            m_left   = 33;
            exp_busy = 1'b1;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            v   = m_last;
            top = 0;
            for (int i = 0; i < NDIGITS; i++) begin
              dig[i] = int'(v % 10);
              v      = v / 10;
              exp_bcd[4*i +: 4] = 4'(dig[i]);
              if (dig[i] != 0) top = i;
            end
            exp_ovf = (v != 0);
            for (int i = 0; i < NDIGITS; i++) begin
              if (exp_ovf) exp_seg[7*i +: 7] = 7'h3F;
`ifdef GPIO_BCD_LEADING_ZERO_BLANK_EN
              else if (i > top) exp_seg[7*i +: 7] = 7'h7F;
`endif
              else exp_seg[7*i +: 7] = seg_tab[dig[i]];
            end
            exp_valid = 1'b1;
            exp_busy  = 1'b0;
          end
        end
      end
      chk_en = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("bcd_out", 80'(bus.bcd_out), 80'(exp_bcd));
        check("seg_out", 80'(bus.seg_out), 80'(exp_seg));
        check("overflow", 80'(bus.overflow), 80'(exp_ovf));
        check("busy", 80'(bus.busy), 80'(exp_busy));
        check("valid", 80'(bus.valid), 80'(exp_valid));
        total++;
        if (bus.busy && bus.valid) begin
          bad++;
          $display("FAIL busy_and_valid: got both 1 required not both");
        end
      end
    end
  end

  // Returns at the negedge where valid is seen; checks edge count when exp_n >= 0.
  task automatic wait_valid(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.valid && n < 200);
    if (exp_n >= 0) check({name, "_latency"}, 80'(n), 80'(exp_n));
    else if (!bus.valid) check({name, "_timeout"}, 80'(0), 80'(1));
  endtask

  task automatic count_events(input int cycles, output int n_valid, output int n_busy);
    n_valid = 0;
    n_busy  = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.valid) n_valid++;
      if (bus.busy)  n_busy++;
    end
  endtask

  initial begin
    int nv, nb, sel;
    rst_n        = 1'b0;
    bus.value_in = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_bcd", 80'(bus.bcd_out), 80'(0));
    check("rst_seg", 80'(bus.seg_out), 80'({NDIGITS{7'h7F}}));
    check("rst_busy", 80'(bus.busy), 80'(0));
    check("rst_valid", 80'(bus.valid), 80'(0));

    rst_n = 1'b1;
    wait_valid("zero", 34);
    check("zero_bcd", 80'(bus.bcd_out), 80'(0));
`ifdef GPIO_BCD_LEADING_ZERO_BLANK_EN
    check("zero_seg", 80'(bus.seg_out), 80'({{7{7'h7F}}, 7'h40}));
`else
    check("zero_seg", 80'(bus.seg_out), 80'({8{7'h40}}));
`endif

    bus.value_in = 32'd12345678;
    wait_valid("v12345678", 34);
    check("v12345678_bcd", 80'(bus.bcd_out), 80'(32'h12345678));
    check("v12345678_seg", 80'(bus.seg_out),
          80'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    check("v12345678_ovf", 80'(bus.overflow), 80'(0));

    bus.value_in = 32'd99999999;
    wait_valid("v99999999", 34);
    check("v99999999_bcd", 80'(bus.bcd_out), 80'(32'h99999999));
    check("v99999999_ovf", 80'(bus.overflow), 80'(0));

    bus.value_in = 32'd100000000;
    wait_valid("v1e8", 34);
    check("v1e8_ovf", 80'(bus.overflow), 80'(1));
    check("v1e8_seg", 80'(bus.seg_out), 80'({8{7'h3F}}));
    check("v1e8_bcd", 80'(bus.bcd_out), 80'(0));

    bus.value_in = 32'hFFFF_FFFF;
    wait_valid("vmax", 34);
    check("vmax_ovf", 80'(bus.overflow), 80'(1));
    check("vmax_bcd", 80'(bus.bcd_out), 80'(32'h94967295));

    // Change mid-conversion: the newer value follows once the first finishes.
    bus.value_in = 32'd5;
    repeat (10) @(negedge clk);
    bus.value_in = 32'd7;
    wait_valid("v5", -1);
    check("v5_bcd", 80'(bus.bcd_out), 80'(5));
    wait_valid("v7", 34);
    check("v7_bcd", 80'(bus.bcd_out), 80'(7));
    count_events(100, nv, nb);
    check("v7_no_repeat", 80'(nv), 80'(0));

    bus.value_in = 32'd42;
    wait_valid("v42", 34);
    count_events(200, nv, nb);
    check("v42_one_valid", 80'(nv), 80'(0));
    check("v42_idle_busy", 80'(nb), 80'(0));

    bus.value_in = 32'd12345678;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 80'(bus.busy), 80'(0));
    check("abort_valid", 80'(bus.valid), 80'(0));
    check("abort_seg", 80'(bus.seg_out), 80'({NDIGITS{7'h7F}}));
    check("abort_bcd", 80'(bus.bcd_out), 80'(0));
    rst_n = 1'b1;
    wait_valid("after_abort", 34);
    check("after_abort_bcd", 80'(bus.bcd_out), 80'(32'h12345678));

    for (int it = 0; it < 60; it++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       bus.value_in = $urandom;
        1:       bus.value_in = $urandom_range(0, 99999999);
        2:       bus.value_in = $urandom_range(0, 999);
        default: bus.value_in = $urandom_range(99999990, 100000010);
      endcase
      repeat ($urandom_range(1, 60)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (80) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gpio_bcd_display.md
Name: gpio_bcd_display

Overview:
- Downstream consumer of the core's `io2_out` / `io3_out` GPIO registers; one instance per output port.
- Watches the 32-bit output word and converts it to decimal with an iterative double-dabble (shift-add-3) engine.
- Drives NDIGITS active-low seven-segment digits on the board, plus the raw BCD digits.
- Conversion is multi-cycle, so the core's ALU path is never loaded with a combinational divider.

Parameters:
- NDIGITS, 8, number of displayed decimal digits; legal range 1..10.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- value_in  input  32  unsigned word from the core GPIO output register
- bcd_out  output  4*NDIGITS  converted BCD digits; digit 0 (ones) in bits [3:0]
- seg_out  output  7*NDIGITS  active-low segments per digit, bit order {g,f,e,d,c,b,a}; digit 0 in bits [6:0]
- overflow  output  1  value_in needs more than NDIGITS decimal digits
- busy  output  1  conversion in progress
- valid  output  1  one-cycle pulse when the outputs have just been updated

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values:
  - bcd_out = 0, overflow = 0, busy = 0, valid = 0.
  - seg_out = all ones (every digit blank, 7'h7F).
  - State = IDLE; internal `first` flag = 1.
- IDLE:
  - Start condition: `first` is set, or value_in differs from `last_value` (the value of the previous completed conversion).
  - On start, at that edge (E0): latch value_in into a 32-bit shift register and into `last_value`; clear the 40-bit (10-digit) BCD accumulator; clear the iteration counter; clear `first`; set busy = 1; go to CONVERT.
- CONVERT (edges E1..E32), one iteration per edge:
  - Every accumulator digit >= 5 gets +3, using 4-bit arithmetic with no carry into the neighbour.
  - Then {accumulator, shift} shifts left by 1.
  - At E32 (counter = 31), go to DONE.
- DONE (edge E33):
  - Register bcd_out = accumulator digits [NDIGITS-1:0].
  - overflow = 1 if any accumulator digit at index >= NDIGITS is nonzero.
  - Register seg_out from the digits.
  - valid = 1 for exactly one cycle; busy = 0; go to IDLE.
- Latency: value_in stable before E0 gives outputs at E33, i.e. 34 edges. Back-to-back changes give one result per 34 cycles.
- value_in changing during CONVERT or DONE is ignored. On return to IDLE it is compared against `last_value`, so the newest value is converted next; intermediate values may be skipped.
- Segment encoding (active-low):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - Digits above 9 cannot occur; any such value encodes as 7F.
- On overflow, every digit of seg_out = 3F (dash). bcd_out still carries the low NDIGITS digits.
- valid and busy are never 1 in the same cycle.
- Reset asserted mid-conversion: abandon the conversion and restore all reset values. The `first` flag forces a fresh conversion after reset is released.
- NDIGITS = 10: overflow is constant 0, since 2^32-1 = 4294967295 fits in 10 digits.

Optional Feature:
- Macro: GPIO_BCD_LEADING_ZERO_BLANK_EN.
- When defined:
  - Every zero digit above the most significant nonzero digit shows as blank (7F).
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - bcd_out is unaffected.
  - Overflow dashes take priority over blanking.
- When undefined: all NDIGITS digits always display, including leading zeros.

Test Plan:
- Reset, value_in = 0, then release reset → valid pulses at edge 34 after release; bcd_out = 0; every seg_out digit = 40 (with macro: digit 0 = 40, digits 1..7 = 7F); busy high for edges E0..E32.
- value_in = 12345678 → bcd_out = 32'h12345678; seg_out digit 7..0 = 79, 24, 30, 19, 12, 02, 78, 00; overflow = 0.
- value_in = 99999999 → bcd_out = 32'h99999999, overflow = 0. Then value_in = 100000000 → overflow = 1, all digits 3F, bcd_out = 0. Then value_in = 32'hFFFFFFFF → overflow = 1, bcd_out = 32'h94967295.
- value_in = 5, then 7 at edge E10, then held → first valid reports bcd_out = 5; second valid 34 edges later reports 7; no third conversion while value_in stays 7.
- value_in = 42 held constant for 200 cycles after the first result → exactly one valid pulse; busy stays 0 afterwards.
- Start converting 12345678; assert rst_n = 0 at E15 for one cycle → outputs at reset values next edge, no valid pulse for the aborted run; a fresh conversion completes 34 edges after release with bcd_out = 32'h12345678.
